// File: rtl/sync_filter_pkg.sv
// Shared types and helpers for the sync_filter_bus channel synchroniser.
// The edge_t encoding is also meant for consumers decoding rise/fall pairs.
package sync_filter_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_t;

  // Counter width able to hold 0 .. filt.
  function automatic int cnt_w(input int filt);
    return $clog2(filt + 1);
  endfunction

  // Direction of an accepted change, given the level being adopted.
  function automatic edge_t edge_of(input logic new_level);
    return new_level ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: W-flop synchroniser, FILT-sample stability filter, edge pulses.
// Edge pulse flops exist only when SYNC_FILTER_BUS_EDGE_EN is defined.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   W       = 3,
  parameter int   FILT    = 4,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic aresetn,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_w(FILT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  logic [W-1:0]  sync_q;
  logic [CW-1:0] cnt_q;
  logic          s;
  logic          take;

  assign s    = sync_q[W-1];
  assign take = (s != out) && (cnt_q == CNT_LAST);

  // Plain shift chain with nothing between stages, so each flop gets a full
  // cycle to resolve metastability. Resetting it to the same value as out
  // keeps reset release from looking like a change.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= {W{RST_BIT}};
    end else begin
      sync_q <= {sync_q[W-2:0], in};
    end
  end

  // Count consecutive samples that disagree with out; any agreement restarts
  // the count, and the threshold hit both adopts s and clears the counter, so
  // cnt_q never passes CNT_LAST.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out   <= RST_BIT;
      cnt_q <= '0;
    end else if (s == out) begin
      cnt_q <= '0;
    end else if (take) begin
      out   <= s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SYNC_FILTER_BUS_EDGE_EN
  edge_t edge_d;

  assign edge_d = take ? edge_of(s) : EDGE_NONE;

  // Registered alongside out, so pulses line up with the cycle out changes.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (edge_d == EDGE_RISE);
      fall <= (edge_d == EDGE_FALL);
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sync_filter_bus.sv
// N-channel synchroniser/debouncer for asynchronous level inputs into clk.
// Define SYNC_FILTER_BUS_EDGE_EN to build rise/fall/changed; otherwise they are 0.
module sync_filter_bus
  import sync_filter_pkg::*;
#(
  parameter int           N       = 8,
  parameter int           W       = 3,
  parameter int           FILT    = 4,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "sync_filter_bus: N must be >= 1");
  end
  if (W < 2) begin : g_bad_w
    $fatal(1, "sync_filter_bus: W must be >= 2");
  end
  if (FILT < 1) begin : g_bad_filt
    $fatal(1, "sync_filter_bus: FILT must be >= 1");
  end

  // Channels are independent; a multi-bit value on in is never coherent here.
  for (genvar i = 0; i < N; i++) begin : g_ch
    sync_filter_ch #(
      .W       (W),
      .FILT    (FILT),
      .RST_BIT (RST_VAL[i])
    ) u_ch (
      .clk     (clk),
      .aresetn (aresetn),
      .in      (in[i]),
      .out     (out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

`ifdef SYNC_FILTER_BUS_EDGE_EN
  assign changed = |(rise | fall);
`else
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_sync_filter_bus.sv
// Directed bench for sync_filter_bus (N=8, W=3, FILT=4, RST_VAL=8'hA5).
// Expected pulses collapse to zero when SYNC_FILTER_BUS_EDGE_EN is not defined.
module tb_sync_filter_bus;

  localparam int         N       = 8;
  localparam int         W       = 3;
  localparam int         FILT    = 4;
  localparam logic [7:0] RST_VAL = 8'hA5;
`ifdef SYNC_FILTER_BUS_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       aresetn;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_filter_bus #(
    .N       (N),
    .W       (W),
    .FILT    (FILT),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .in      (din),
    .out     (dout),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input logic [7:0] e_out,
                           input logic [7:0] e_rise, input logic [7:0] e_fall);
    logic [7:0] r;
    logic [7:0] f;
    r = EDGE_EN ? e_rise : 8'h00;
    f = EDGE_EN ? e_fall : 8'h00;
    check({tag, " out"}, 32'(dout), 32'(e_out));
    check({tag, " rise"}, 32'(rise), 32'(r));
    check({tag, " fall"}, 32'(fall), 32'(f));
    check({tag, " changed"}, 32'(changed), 32'(|(r | f)));
  endtask

  task automatic tick_check(input string tag, input logic [7:0] e_out,
                            input logic [7:0] e_rise, input logic [7:0] e_fall);
    tick();
    check_now(tag, e_out, e_rise, e_fall);
  endtask

  // Hold din for n-1 quiet cycles, then expect out to move with one pulse, then quiet.
  task automatic expect_step(input string tag, input logic [7:0] new_in,
                             input logic [7:0] old_out, input logic [7:0] new_out);
    din = new_in;
    for (int i = 1; i < W + FILT; i++) tick_check({tag, " quiet"}, old_out, 8'h00, 8'h00);
    tick_check({tag, " edge"}, new_out, new_out & ~old_out, old_out & ~new_out);
    tick_check({tag, " after"}, new_out, 8'h00, 8'h00);
  endtask

  initial begin
    // Reset with in != RST_VAL: no pulse on release, change arrives W+FILT clks later.
    aresetn = 1'b0;
    din     = 8'h00;
    tick();
    check_now("reset", RST_VAL, 8'h00, 8'h00);
    tick();
    check_now("reset hold", RST_VAL, 8'h00, 8'h00);
    @(negedge clk);
    aresetn = 1'b1;
    expect_step("release", 8'h00, RST_VAL, 8'h00);

    // Latency on a single channel.
    expect_step("latency", 8'h01, 8'h00, 8'h01);

    // Glitch of 3 clks on in[3] is rejected.
    din = 8'h09;
    for (int i = 0; i < 3; i++) tick_check("glitch3 hi", 8'h01, 8'h00, 8'h00);
    din = 8'h01;
    for (int i = 0; i < 8; i++) tick_check("glitch3 lo", 8'h01, 8'h00, 8'h00);

    // Exactly 4 clks is accepted; the return to 0 is then filtered in turn.
    din = 8'h09;
    for (int i = 1; i <= 6; i++) begin
      tick_check("pulse4 wait", 8'h01, 8'h00, 8'h00);
      if (i == 4) din = 8'h01;
    end
    tick_check("pulse4 rise", 8'h09, 8'h08, 8'h00);
    for (int i = 8; i <= 10; i++) tick_check("pulse4 hold", 8'h09, 8'h00, 8'h00);
    tick_check("pulse4 fall", 8'h01, 8'h00, 8'h08);
    tick_check("pulse4 after", 8'h01, 8'h00, 8'h00);

    // Chatter on in[5]: the single 0 sample restarts the count.
    begin
      logic [7:0] chatter;
      chatter = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
        din = {2'b00, chatter[i], 5'b00001};
        if (i < 7) tick_check("chatter", 8'h01, 8'h00, 8'h00);
      end
      tick_check("chatter", 8'h01, 8'h00, 8'h00);
      for (int i = 9; i <= 10; i++) tick_check("chatter wait", 8'h01, 8'h00, 8'h00);
      tick_check("chatter rise", 8'h21, 8'h20, 8'h00);
      tick_check("chatter after", 8'h21, 8'h00, 8'h00);
    end

    // Two channels falling together, then all eight rising together.
    expect_step("dual fall", 8'h00, 8'h21, 8'h00);
    expect_step("all rise", 8'hFF, 8'h00, 8'hFF);

    // Reset mid-filter: count discarded, out back to RST_VAL at once, no pulse.
    din = 8'h00;
    for (int i = 0; i < W + 2; i++) tick_check("midfilt", 8'hFF, 8'h00, 8'h00);
    aresetn = 1'b0;
    #1;
    check_now("midfilt reset", RST_VAL, 8'h00, 8'h00);
    tick_check("midfilt reset hold", RST_VAL, 8'h00, 8'h00);
    @(negedge clk);
    aresetn = 1'b1;
    expect_step("midfilt release", 8'h00, RST_VAL, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
